// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access sequencer: CSR addresses, Zicsr
// funct3 encodings, trap causes, FSM state encoding and the decode of the
// implemented machine-mode CSR set.
package csr_access_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam logic [31:0] CAUSE_ECALL_M      = 32'd11;
    localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_TRAP  = 3'd3,
        ST_VEC   = 3'd4,
        ST_RET   = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // True for the CSR addresses the attached register file actually holds.
    function automatic logic csr_implemented(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP: csr_implemented = 1'b1;
            default:                                  csr_implemented = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_access_unit_wdata_alu.sv
// Write-data computation for Zicsr ops: new CSR value from the old value and
// the operand, plus the flag that says the write must not happen at all.
module csr_wdata_alu
    import csr_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] old_val,
    input  logic [31:0] operand,
    input  logic        operand_zero,
    output logic [31:0] new_val,
    output logic        suppress
);

    // Set/clear with a zero operand field is a pure read; swap always writes.
    always_comb begin
        new_val  = old_val;
        suppress = 1'b1;
        case (funct3)
            F3_RW, F3_RWI: begin
                new_val  = operand;
                suppress = 1'b0;
            end
            F3_RS, F3_RSI: begin
                new_val  = old_val | operand;
                suppress = operand_zero;
            end
            F3_RC, F3_RCI: begin
                new_val  = old_val & ~operand;
                suppress = operand_zero;
            end
            default: begin
                new_val  = old_val;
                suppress = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Sequencer between decode/execute and the machine-mode CSR file. CSR ops are
// a read followed by an optional one-cycle write; ecall/mret fire a strobe and
// then read the redirect target back from the file.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter logic [31:0] ECALL_CAUSE = CAUSE_ECALL_M,
    parameter logic [11:0] MTVEC_ADDR  = CSR_MTVEC,
    parameter logic [11:0] MEPC_ADDR   = CSR_MEPC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        op_ecall,
    input  logic        op_mret,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_sel,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        illegal,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [11:0] csr_addr,
    input  logic [31:0] csr_rdata,
    output logic [11:0] wr1_addr,
    output logic [31:0] data1_out,
    output logic        wcsr_n,
    output logic        ecall,
    output logic        mret,
    output logic [31:0] mepc_out,
    output logic [31:0] mcause_out
);

    state_e      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [11:0] sel_q, sel_d;
    logic [31:0] rs1_q, rs1_d;
    logic [4:0]  zimm_q, zimm_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] new_q, new_d;
    logic        illegal_q, illegal_d;
    logic        redir_q, redir_d;
    logic [31:0] rpc_q, rpc_d;

    logic [31:0] operand;
    logic [31:0] alu_new;
    logic        alu_suppress;

    // Immediate forms take the zero-extended zimm field as the operand.
    assign operand = f3_q[2] ? {27'b0, zimm_q} : rs1_q;

    csr_wdata_alu u_alu (
        .funct3       (f3_q),
        .old_val      (csr_rdata),
        .operand      (operand),
        .operand_zero (zimm_q == 5'd0),
        .new_val      (alu_new),
        .suppress     (alu_suppress)
    );

    // Next state, captured operands and CSR-file side outputs.
    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        sel_d     = sel_q;
        rs1_d     = rs1_q;
        zimm_d    = zimm_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        new_d     = new_q;
        illegal_d = illegal_q;
        redir_d   = redir_q;
        rpc_d     = rpc_q;

        busy       = 1'b0;
        done       = 1'b0;
        csr_addr   = 12'h000;
        wr1_addr   = 12'h000;
        data1_out  = 32'h0;
        wcsr_n     = 1'b1;
        ecall      = 1'b0;
        mret       = 1'b0;
        mepc_out   = 32'h0;
        mcause_out = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    f3_d      = funct3;
                    sel_d     = csr_sel;
                    rs1_d     = rs1_data;
                    zimm_d    = zimm;
                    pc_d      = pc;
                    rd_d      = 32'h0;
                    illegal_d = 1'b0;
                    redir_d   = 1'b0;
                    if (op_ecall)     state_d = ST_TRAP;
                    else if (op_mret) state_d = ST_RET;
                    else              state_d = ST_READ;
                end
            end
            ST_READ: begin
                busy     = 1'b1;
                csr_addr = sel_q;
                rd_d     = csr_rdata;
                new_d    = alu_new;
                // Top two address bits 11 mark read-only space.
                if (!csr_implemented(sel_q) ||
                    (!alu_suppress && sel_q[11:10] == 2'b11)) begin
                    illegal_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (alu_suppress) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy      = 1'b1;
                // Reset gates the strobe so an aborted write never commits
                // on this cycle's negedge.
                wcsr_n    = reset;
                wr1_addr  = sel_q;
                data1_out = new_q;
                state_d   = ST_DONE;
            end
            ST_TRAP: begin
                busy       = 1'b1;
                ecall      = !reset;
                mepc_out   = pc_q;
                mcause_out = ECALL_CAUSE;
                state_d    = ST_VEC;
            end
            ST_VEC: begin
                busy     = 1'b1;
                csr_addr = MTVEC_ADDR;
                rpc_d    = {csr_rdata[31:2], 2'b00};
                redir_d  = 1'b1;
                rd_d     = 32'h0;
                state_d  = ST_DONE;
            end
            ST_RET: begin
                busy     = 1'b1;
                mret     = !reset;
                csr_addr = MEPC_ADDR;
                rpc_d    = csr_rdata;
                redir_d  = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_data        = rd_q;
    assign redirect_pc    = rpc_q;
    assign illegal        = done & illegal_q;
    assign redirect_valid = done & redir_q;

    // State and operand registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            f3_q      <= 3'b000;
            sel_q     <= 12'h000;
            rs1_q     <= 32'h0;
            zimm_q    <= 5'd0;
            pc_q      <= 32'h0;
            rd_q      <= 32'h0;
            new_q     <= 32'h0;
            illegal_q <= 1'b0;
            redir_q   <= 1'b0;
            rpc_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            sel_q     <= sel_d;
            rs1_q     <= rs1_d;
            zimm_q    <= zimm_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            new_q     <= new_d;
            illegal_q <= illegal_d;
            redir_q   <= redir_d;
            rpc_q     <= rpc_d;
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small behavioural CSR file
// (combinational read, negedge write, ecall/mret mstatus handling).
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        op_ecall = 1'b0;
    logic        op_mret = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [11:0] csr_sel = 12'h000;
    logic [31:0] rs1_data = 32'h0;
    logic [4:0]  zimm = 5'd0;
    logic [31:0] pc = 32'h0;
    logic        busy, done, illegal, redirect_valid, wcsr_n, ecall, mret;
    logic [31:0] rd_data, redirect_pc, csr_rdata, data1_out, mepc_out, mcause_out;
    logic [11:0] csr_addr, wr1_addr;

    int n_cmp = 0;
    int n_bad = 0;

    csr_access_unit dut (
        .clk(clk), .reset(reset), .req(req), .op_ecall(op_ecall), .op_mret(op_mret),
        .funct3(funct3), .csr_sel(csr_sel), .rs1_data(rs1_data), .zimm(zimm), .pc(pc),
        .busy(busy), .done(done), .rd_data(rd_data), .illegal(illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_addr(csr_addr), .csr_rdata(csr_rdata), .wr1_addr(wr1_addr),
        .data1_out(data1_out), .wcsr_n(wcsr_n), .ecall(ecall), .mret(mret),
        .mepc_out(mepc_out), .mcause_out(mcause_out)
    );

    always #5 clk = ~clk;

    // Behavioural CSR file plus strobe monitor.
    logic [31:0] m_mstatus = 32'h1888, m_mie = 0, m_mtvec = 0, m_mscratch = 0;
    logic [31:0] m_mepc = 0, m_mcause = 0, m_mtval = 0, m_mip = 0;
    int          wcnt = 0, ecnt = 0, mcnt = 0;
    logic [11:0] w_addr = 0;
    logic [31:0] w_data = 0, e_mepc = 0, e_mcause = 0;

    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = m_mstatus;
            12'h304: csr_rdata = m_mie;
            12'h305: csr_rdata = m_mtvec;
            12'h340: csr_rdata = m_mscratch;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            12'h343: csr_rdata = m_mtval;
            12'h344: csr_rdata = m_mip;
            default: csr_rdata = 32'h0;
        endcase
    end

    always @(negedge clk) begin
        if (!wcsr_n) begin
            wcnt++;
            w_addr = wr1_addr;
            w_data = data1_out;
            case (wr1_addr)
                12'h300: m_mstatus  = data1_out;
                12'h304: m_mie      = data1_out;
                12'h305: m_mtvec    = data1_out;
                12'h340: m_mscratch = data1_out;
                12'h341: m_mepc     = data1_out;
                12'h342: m_mcause   = data1_out;
                12'h343: m_mtval    = data1_out;
                12'h344: m_mip      = data1_out;
                default: ;
            endcase
        end
        if (ecall) begin
            ecnt++;
            e_mepc       = mepc_out;
            e_mcause     = mcause_out;
            m_mepc       = mepc_out;
            m_mcause     = mcause_out;
            m_mstatus[7] = m_mstatus[3];
            m_mstatus[3] = 1'b0;
        end
        if (mret) begin
            mcnt++;
            m_mstatus[3] = m_mstatus[7];
            m_mstatus[7] = 1'b1;
        end
    end

    // Issue one request and wait for done. lat counts edges from the accept
    // edge (inclusive) to the edge that raises done; -1 on timeout.
    task automatic run_op(input logic ec, input logic mr, input logic [2:0] f3,
                          input logic [11:0] sel, input logic [31:0] rs1,
                          input logic [4:0] zi, input logic [31:0] p,
                          output int lat, output logic [31:0] rd, output logic ill,
                          output logic rv, output logic [31:0] rpc,
                          output int nw, output int ne, output int nm);
        int w0, e0, m0;
        w0 = wcnt; e0 = ecnt; m0 = mcnt;
        op_ecall = ec; op_mret = mr; funct3 = f3; csr_sel = sel;
        rs1_data = rs1; zimm = zi; pc = p; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; op_ecall = 1'b0; op_mret = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        rd = rd_data; ill = illegal; rv = redirect_valid; rpc = redirect_pc;
        nw = wcnt - w0; ne = ecnt - e0; nm = mcnt - m0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (wcsr_n !== 1'b1)    begin n_bad++; $display("FAIL reset_wcsr_n: got %b want 1", wcsr_n); end
        n_cmp++; if ({ecall, mret, illegal, redirect_valid} !== 4'b0)
                                         begin n_bad++; $display("FAIL reset_strobes: got %b want 0000", {ecall, mret, illegal, redirect_valid}); end
        n_cmp++; if (csr_addr !== 12'h0) begin n_bad++; $display("FAIL reset_csr_addr: got %h want 000", csr_addr); end
        n_cmp++; if ({rd_data, redirect_pc, data1_out, mepc_out, mcause_out} !== 160'h0)
                                         begin n_bad++; $display("FAIL reset_data_outs: got %h/%h/%h want 0", rd_data, redirect_pc, data1_out); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_csrrw();
        int lat, nw, ne, nm; logic [31:0] rd, rpc; logic ill, rv;
        run_op(0, 0, 3'b001, 12'h305, 32'h100, 5'd1, 32'h0, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if (lat !== 3)           begin n_bad++; $display("FAIL rw_latency: got %0d want 3", lat); end
        n_cmp++; if (nw !== 1)            begin n_bad++; $display("FAIL rw_wcsr_pulses: got %0d want 1", nw); end
        n_cmp++; if (w_addr !== 12'h305)  begin n_bad++; $display("FAIL rw_wr1_addr: got %h want 305", w_addr); end
        n_cmp++; if (w_data !== 32'h100)  begin n_bad++; $display("FAIL rw_data1_out: got %h want 00000100", w_data); end
        n_cmp++; if (rd !== 32'h0)        begin n_bad++; $display("FAIL rw_rd_data: got %h want 0", rd); end
        n_cmp++; if ({ill, rv} !== 2'b00) begin n_bad++; $display("FAIL rw_flags: got %b want 00", {ill, rv}); end
        run_op(0, 0, 3'b010, 12'h305, 32'hFFFF, 5'd0, 32'h0, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if (rd !== 32'h100)      begin n_bad++; $display("FAIL rw_readback: got %h want 00000100", rd); end
    endtask

    task automatic test_suppress();
        int lat, nw, ne, nm; logic [31:0] rd, rpc; logic ill, rv;
        run_op(0, 0, 3'b010, 12'h300, 32'hFFFF_FFFF, 5'd0, 32'h0, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if (lat !== 2)          begin n_bad++; $display("FAIL rs0_latency: got %0d want 2", lat); end
        n_cmp++; if (nw !== 0)           begin n_bad++; $display("FAIL rs0_no_write: got %0d want 0", nw); end
        n_cmp++; if (rd !== 32'h1888)    begin n_bad++; $display("FAIL rs0_rd_data: got %h want 00001888", rd); end
        run_op(0, 0, 3'b111, 12'h300, 32'h0, 5'd8, 32'h0, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if (nw !== 1)           begin n_bad++; $display("FAIL rci_wcsr_pulses: got %0d want 1", nw); end
        n_cmp++; if (w_data !== 32'h1880) begin n_bad++; $display("FAIL rci_data1_out: got %h want 00001880", w_data); end
        n_cmp++; if (rd !== 32'h1888)    begin n_bad++; $display("FAIL rci_rd_data: got %h want 00001888", rd); end
        // Restore MIE via RSI and point mtvec at 0x203 (low bits must be masked).
        run_op(0, 0, 3'b110, 12'h300, 32'h0, 5'd8, 32'h0, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if (w_data !== 32'h1888) begin n_bad++; $display("FAIL rsi_data1_out: got %h want 00001888", w_data); end
        run_op(0, 0, 3'b001, 12'h305, 32'h203, 5'd2, 32'h0, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if (rd !== 32'h100)     begin n_bad++; $display("FAIL rw2_rd_data: got %h want 00000100", rd); end
    endtask

    task automatic test_ecall();
        int lat, nw, ne, nm; logic [31:0] rd, rpc; logic ill, rv;
        // op_mret also high: ecall must win.
        run_op(1, 1, 3'b001, 12'h340, 32'h55, 5'd3, 32'h80, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if (lat !== 3)             begin n_bad++; $display("FAIL ecall_latency: got %0d want 3", lat); end
        n_cmp++; if ({ne, nm, nw} !== {32'd1, 32'd0, 32'd0})
                                            begin n_bad++; $display("FAIL ecall_strobes: got e=%0d m=%0d w=%0d want 1/0/0", ne, nm, nw); end
        n_cmp++; if (e_mepc !== 32'h80)     begin n_bad++; $display("FAIL ecall_mepc_out: got %h want 00000080", e_mepc); end
        n_cmp++; if (e_mcause !== 32'd11)   begin n_bad++; $display("FAIL ecall_mcause_out: got %h want 0000000b", e_mcause); end
        n_cmp++; if (rpc !== 32'h200)       begin n_bad++; $display("FAIL ecall_redirect_pc: got %h want 00000200", rpc); end
        n_cmp++; if ({rv, ill} !== 2'b10)   begin n_bad++; $display("FAIL ecall_flags: got %b want 10", {rv, ill}); end
        n_cmp++; if (rd !== 32'h0)          begin n_bad++; $display("FAIL ecall_rd_data: got %h want 0", rd); end
        n_cmp++; if ({m_mstatus[7], m_mstatus[3]} !== 2'b10)
                                            begin n_bad++; $display("FAIL ecall_mstatus: got mpie/mie=%b want 10", {m_mstatus[7], m_mstatus[3]}); end
    endtask

    task automatic test_mret();
        int lat, nw, ne, nm; logic [31:0] rd, rpc; logic ill, rv;
        run_op(0, 1, 3'b000, 12'h000, 32'h0, 5'd0, 32'h999, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if (lat !== 2)           begin n_bad++; $display("FAIL mret_latency: got %0d want 2", lat); end
        n_cmp++; if ({nm, ne, nw} !== {32'd1, 32'd0, 32'd0})
                                          begin n_bad++; $display("FAIL mret_strobes: got m=%0d e=%0d w=%0d want 1/0/0", nm, ne, nw); end
        n_cmp++; if (rpc !== 32'h80)      begin n_bad++; $display("FAIL mret_redirect_pc: got %h want 00000080", rpc); end
        n_cmp++; if (rv !== 1'b1)         begin n_bad++; $display("FAIL mret_redirect_valid: got %b want 1", rv); end
        run_op(0, 0, 3'b010, 12'h300, 32'h0, 5'd0, 32'h0, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if (rd !== 32'h1888)     begin n_bad++; $display("FAIL mret_mstatus: got %h want 00001888", rd); end
    endtask

    task automatic test_illegal();
        int lat, nw, ne, nm; logic [31:0] rd, rpc; logic ill, rv;
        run_op(0, 0, 3'b001, 12'hC00, 32'h1, 5'd1, 32'h0, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if ({ill, nw, lat} !== {1'b1, 32'd0, 32'd2})
                                  begin n_bad++; $display("FAIL illegal_c00: got ill=%b w=%0d lat=%0d want 1/0/2", ill, nw, lat); end
        run_op(0, 0, 3'b001, 12'h7C0, 32'h1, 5'd1, 32'h0, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if ({ill, nw, lat} !== {1'b1, 32'd0, 32'd2})
                                  begin n_bad++; $display("FAIL illegal_7c0: got ill=%b w=%0d lat=%0d want 1/0/2", ill, nw, lat); end
        run_op(0, 0, 3'b010, 12'h305, 32'h0, 5'd0, 32'h0, lat, rd, ill, rv, rpc, nw, ne, nm);
        n_cmp++; if (ill !== 1'b0) begin n_bad++; $display("FAIL legal_after_illegal: got %b want 0", ill); end
    endtask

    task automatic test_reset_in_write();
        int w0;
        op_ecall = 0; op_mret = 0; funct3 = 3'b001; csr_sel = 12'h340;
        rs1_data = 32'hDEAD; zimm = 5'd1; req = 1'b1;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (wcsr_n !== 1'b0) begin n_bad++; $display("FAIL rst_wr_in_write: got wcsr_n=%b want 0", wcsr_n); end
        w0 = wcnt;
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({wcsr_n, busy, done} !== 3'b100)
                                      begin n_bad++; $display("FAIL rst_wr_outputs: got wcsr_n/busy/done=%b want 100", {wcsr_n, busy, done}); end
        n_cmp++; if (wcnt !== w0)     begin n_bad++; $display("FAIL rst_wr_no_commit: got %0d writes want 0", wcnt - w0); end
        n_cmp++; if (m_mscratch !== 32'h0) begin n_bad++; $display("FAIL rst_wr_target: got %h want 0", m_mscratch); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n;
        op_ecall = 0; op_mret = 0; funct3 = 3'b001; csr_sel = 12'h340;
        rs1_data = 32'h11; zimm = 5'd1; req = 1'b1;
        @(posedge clk); #1;
        rs1_data = 32'h22;  // held req with new data must not disturb op A
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++; if ({done, rd_data} !== {1'b1, 32'h0})
                                     begin n_bad++; $display("FAIL b2b_first_done: got done=%b rd=%h want 1/0", done, rd_data); end
        n_cmp++; if (m_mscratch !== 32'h11) begin n_bad++; $display("FAIL b2b_first_write: got %h want 00000011", m_mscratch); end
        @(posedge clk); #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL b2b_idle_gap: got busy/done=%b want 00", {busy, done}); end
        @(posedge clk); #1; req = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: got busy=%b want 1", busy); end
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++; if ({done, rd_data} !== {1'b1, 32'h11})
                                     begin n_bad++; $display("FAIL b2b_second_done: got done=%b rd=%h want 1/00000011", done, rd_data); end
        n_cmp++; if (m_mscratch !== 32'h22) begin n_bad++; $display("FAIL b2b_second_write: got %h want 00000022", m_mscratch); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_suppress();
        test_ecall();
        test_mret();
        test_illegal();
        test_reset_in_write();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator-side sequencer that drives the machine-mode CSR register file.
- Turns decoded Zicsr instructions (CSRRW/S/C and the immediate forms) into a read-then-conditional-write sequence on the CSR file's read port and negedge-write port.
- Issues the ecall/mret trap strobes with mepc/mcause values, then reads back mtvec or mepc to give the core a redirect PC.
- Sits between the decode/execute stage, which stalls on busy, and the CSR file.

Parameters:
- ECALL_CAUSE, 32'd11, mcause value written on ecall (environment call from M-mode).
- MTVEC_ADDR, 12'h305, CSR address read for the trap vector.
- MEPC_ADDR, 12'h341, CSR address read for the mret target.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start pulse; sampled only in IDLE.
- op_ecall  in  1  request is ecall.
- op_mret  in  1  request is mret.
- funct3  in  3  Zicsr funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- csr_sel  in  12  CSR address from the instruction.
- rs1_data  in  32  register source operand.
- zimm  in  5  immediate/rs1 index field, zero-extended for the I forms.
- pc  in  32  PC of the requesting instruction.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle completion pulse.
- rd_data  out  32  old CSR value; valid while done=1.
- illegal  out  1  valid with done; unimplemented address, or write to read-only space.
- redirect_valid  out  1  valid with done for ecall/mret.
- redirect_pc  out  32  trap/return target.
- csr_addr  out  12  CSR file read address.
- csr_rdata  in  32  CSR file combinational read data.
- wr1_addr  out  12  CSR file write address.
- data1_out  out  32  CSR file write data.
- wcsr_n  out  1  active-low write enable.
- ecall  out  1  trap strobe to the CSR file.
- mret  out  1  return strobe to the CSR file.
- mepc_out  out  32  exception PC presented with the ecall strobe.
- mcause_out  out  32  cause presented with the ecall strobe.

Behaviour:
- Reset values (synchronous, takes effect at the next edge, aborts any operation):
  - state=IDLE.
  - busy, done, illegal, redirect_valid, ecall, mret all 0.
  - wcsr_n=1.
  - rd_data, redirect_pc, csr_addr, wr1_addr, data1_out, mepc_out, mcause_out all 0.
- A reset during WRITE or TRAP deasserts wcsr_n/ecall at that edge; no partial write may follow.
- Request capture:
  - In IDLE with req=1, latch funct3, csr_sel, rs1_data, zimm and pc.
  - Priority: op_ecall > op_mret > CSR op.
  - req while busy is ignored; the core must hold it.
- States: IDLE, READ, WRITE, TRAP, VEC, RET, DONE.
- CSR op path:
  - IDLE -> READ: csr_addr=csr_sel. At the next edge capture csr_rdata into old and compute new.
  - Implemented set: 300, 304, 305, 340-344.
  - If the address is unimplemented, or a write is required and csr_sel[11:10]==2'b11: go READ -> DONE with illegal=1 and no write.
  - Else if the write is suppressed: READ -> DONE.
  - Else: READ -> WRITE, driving wcsr_n=0, wr1_addr=csr_sel, data1_out=new for exactly one cycle. The CSR file commits on that cycle's negedge. Then WRITE -> DONE.
- Write values, operand = rs1_data, or {27'b0,zimm} for the I forms:
  - RW: new=operand.
  - RS: new=old|operand.
  - RC: new=old&~operand.
- Write suppression: RS/RC/RSI/RCI with operand field zero (rs1 index or zimm ==0) never write. RW/RWI always write.
- Latency after the accept edge: 3 edges to the done edge with a write; 2 edges without.
- Ecall path:
  - IDLE -> TRAP: ecall=1 for one cycle, mepc_out=pc_q, mcause_out=ECALL_CAUSE.
  - TRAP -> VEC: csr_addr=MTVEC_ADDR; capture redirect_pc={csr_rdata[31:2],2'b00}.
  - VEC -> DONE with redirect_valid=1 and rd_data=0.
- Mret path:
  - IDLE -> RET: mret=1 for one cycle, csr_addr=MEPC_ADDR; capture redirect_pc=csr_rdata (mepc is unaffected by mret).
  - RET -> DONE with redirect_valid=1.
- DONE: done=1 for one cycle, then -> IDLE. busy=0 in DONE so a new req is accepted on the following IDLE cycle.
- Strobes:
  - ecall, mret and wcsr_n=0 are mutually exclusive and each lasts exactly one cycle per operation.
  - Outside those cycles, wcsr_n=1 and ecall=mret=0.
- csr_addr=0 in IDLE/DONE.

Decomposition:
- Shared package:
  - CSR address constants (MSTATUS..MIP).
  - funct3 encodings.
  - Cause codes (ECALL_M=11, ILLEGAL_INSN=2).
  - State enum encoding.
  - An is-implemented-CSR function.
- One sub-module, csr_wdata_alu: combinational; takes funct3, old, operand and operand-zero; returns new value and write-suppress flag.

Test Plan:
- CSRRW 0x305, rs1_data=0x0000_0100: wcsr_n=0 one cycle with wr1_addr=305/data1_out=100; done 3 cycles after accept; rd_data=old mtvec (0); readback mtvec=0x100.
- CSRRS 0x300, rs1 index=0: no wcsr_n pulse; done after 2 cycles; rd_data=0x1888 (mstatus reset); CSRRCI 0x300 zimm=8 -> data1_out=0x1880.
- ecall at pc=0x80 with mtvec=0x200: ecall=1 one cycle, mepc_out=0x80, mcause_out=11; done with redirect_pc=0x200; mstatus[3]=0, mstatus[7]=1.
- mret after the above: mret=1 one cycle; redirect_pc=0x80; mstatus[3] restored to 1.
- CSRRW to 0xC00 and to 0x7C0: illegal=1 with done; no wcsr_n pulse.
- reset asserted in the WRITE cycle: next edge wcsr_n=1, busy=0, state IDLE; target CSR unchanged. A req held during busy is accepted only after done.
